// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline-register bundle: IF-side instruction inputs, the WB write
// port, EX-stage hazard info, and the registered ID/EX outputs.
interface id_ex_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              i_valid;
  logic [31:0]       i_next_pc;
  logic [31:0]       i_instruction;
  logic              i_reg_write;
  logic [ADDR_W-1:0] i_write_register;
  logic [DATA_W-1:0] i_write_data;
  logic              i_ex_mem_read;
  logic [ADDR_W-1:0] i_ex_rt;
  logic              i_flush;

  logic              o_stall;
  logic              o_valid;
  logic [31:0]       o_next_pc;
  logic [DATA_W-1:0] o_read_data_1;
  logic [DATA_W-1:0] o_read_data_2;
  logic [DATA_W-1:0] o_imm;
  logic [ADDR_W-1:0] o_rs;
  logic [ADDR_W-1:0] o_rt;
  logic [ADDR_W-1:0] o_rd;
  logic [5:0]        o_opcode;
  logic [5:0]        o_funct;
  logic [15:0]       o_stall_count;

  // Driver side (IF/WB/EX stages or a testbench)
  modport master (
    output i_valid, i_next_pc, i_instruction, i_reg_write, i_write_register,
           i_write_data, i_ex_mem_read, i_ex_rt, i_flush,
    input  o_stall, o_valid, o_next_pc, o_read_data_1, o_read_data_2, o_imm,
           o_rs, o_rt, o_rd, o_opcode, o_funct, o_stall_count
  );

  // The ID stage itself
  modport slave (
    input  i_valid, i_next_pc, i_instruction, i_reg_write, i_write_register,
           i_write_data, i_ex_mem_read, i_ex_rt, i_flush,
    output o_stall, o_valid, o_next_pc, o_read_data_1, o_read_data_2, o_imm,
           o_rs, o_rt, o_rd, o_opcode, o_funct, o_stall_count
  );
endinterface

// File: rtl/id_ex_pipe.sv
// Instruction decode stage: field decode, immediate extension, register file
// with write-through reads, load-use hazard detection and the ID/EX register.
module id_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  id_ex_pipe_if.slave   bus
);
  localparam int NREGS = 2**ADDR_W;

  logic [5:0]        opcode, funct;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rd1, rd2;
  logic              wb_en, hazard, bubble;

  logic [DATA_W-1:0] rf_q [NREGS];

  logic              valid_d, valid_q;
  logic [31:0]       next_pc_d, next_pc_q;
  logic [DATA_W-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
  logic [ADDR_W-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [5:0]        opcode_d, opcode_q, funct_d, funct_q;
  logic [15:0]       stall_count_d, stall_count_q;

  // Field decode; register fields are resized to ADDR_W (zero-extend or truncate)
  always_comb begin
    opcode = bus.i_instruction[31:26];
    rs     = ADDR_W'(bus.i_instruction[25:21]);
    rt     = ADDR_W'(bus.i_instruction[20:16]);
    rd     = ADDR_W'(bus.i_instruction[15:11]);
    funct  = bus.i_instruction[5:0];
    imm16  = bus.i_instruction[15:0];
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: imm_ext = DATA_W'(imm16);            // logical ops
      6'h0F:               imm_ext = DATA_W'({imm16, 16'h0000}); // LUI
      default:             imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
    endcase
  end

  // Register reads with same-cycle WB forwarding; entry 0 is hardwired to zero
  always_comb begin
    wb_en = bus.i_reg_write && (bus.i_write_register != '0);
    if (rs == '0)                                rd1 = '0;
    else if (wb_en && bus.i_write_register == rs) rd1 = bus.i_write_data;
    else                                          rd1 = rf_q[rs];
    if (rt == '0)                                rd2 = '0;
    else if (wb_en && bus.i_write_register == rt) rd2 = bus.i_write_data;
    else                                          rd2 = rf_q[rt];
  end

  // Load-use hazard; a flush squashes the instruction so it never stalls
  always_comb begin
    hazard = bus.i_valid && bus.i_ex_mem_read && (bus.i_ex_rt != '0) &&
             ((bus.i_ex_rt == rs) || (bus.i_ex_rt == rt));
    bubble = bus.i_flush || hazard || !bus.i_valid;
  end

  assign bus.o_stall = hazard && !bus.i_flush;

  // Next-state of the ID/EX register: a bubble clears every field
  always_comb begin
    valid_d   = 1'b0;
    next_pc_d = '0;
    rd1_d     = '0;
    rd2_d     = '0;
    imm_d     = '0;
    rs_d      = '0;
    rt_d      = '0;
    rd_d      = '0;
    opcode_d  = '0;
    funct_d   = '0;
    if (!bubble) begin
      valid_d   = 1'b1;
      next_pc_d = bus.i_next_pc;
      rd1_d     = rd1;
      rd2_d     = rd2;
      imm_d     = imm_ext;
      rs_d      = rs;
      rt_d      = rt;
      rd_d      = rd;
      opcode_d  = opcode;
      funct_d   = funct;
    end
    stall_count_d = stall_count_q;
    if (bus.o_stall && stall_count_q != 16'hFFFF)
      stall_count_d = stall_count_q + 16'd1;
  end

  // ID/EX register and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= 1'b0;
      next_pc_q     <= '0;
      rd1_q         <= '0;
      rd2_q         <= '0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      opcode_q      <= '0;
      funct_q       <= '0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      next_pc_q     <= next_pc_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      imm_q         <= imm_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rd_q          <= rd_d;
      opcode_q      <= opcode_d;
      funct_q       <= funct_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Register file write port; reset clears every entry and discards WB writes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[bus.i_write_register] <= bus.i_write_data;
    end
  end

  assign bus.o_valid       = valid_q;
  assign bus.o_next_pc     = next_pc_q;
  assign bus.o_read_data_1 = rd1_q;
  assign bus.o_read_data_2 = rd2_q;
  assign bus.o_imm         = imm_q;
  assign bus.o_rs          = rs_q;
  assign bus.o_rt          = rt_q;
  assign bus.o_rd          = rd_q;
  assign bus.o_opcode      = opcode_q;
  assign bus.o_funct       = funct_q;
  assign bus.o_stall_count = stall_count_q;
endmodule
